// File: rtl/async_receiver.sv
// UART receiver (8N1, LSB first). A fractional tick generator oversamples the line,
// a saturating counter filters glitches, and the FSM samples each bit near mid-cell.
module async_receiver #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data
);

    localparam int          OsWidth  = $clog2(Oversampling);
    localparam logic [32:0] AccInc   = 33'(Baud) * 33'(Oversampling);
    localparam logic [32:0] AccLimit = 33'(ClkFrequency);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] BIT0  = 4'd2;
    localparam logic [3:0] BIT7  = 4'd9;
    localparam logic [3:0] STOP  = 4'd10;

    logic [32:0]        acc;
    logic [32:0]        accSum;
    logic               tick;
    logic [1:0]         rxSync;
    logic [1:0]         filtCnt;
    logic [1:0]         filtCntNext;
    logic               filtBit;
    logic [OsWidth-1:0] osCnt;
    logic               sampleNow;
    logic [3:0]         state;
    logic [7:0]         shiftReg;

    // Accumulator stays below ClkFrequency, so one extra bit above 32 covers the sum.
    assign accSum = acc + AccInc;
    assign tick   = (accSum >= AccLimit);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (tick) begin
            acc <= accSum - AccLimit;
        end else begin
            acc <= accSum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxSync <= 2'b11;
        end else begin
            rxSync <= {rxSync[0], RxD};
        end
    end

    always_comb begin
        filtCntNext = filtCnt;
        if (rxSync[1] && filtCnt != 2'd3) begin
            filtCntNext = filtCnt + 2'd1;
        end else if (!rxSync[1] && filtCnt != 2'd0) begin
            filtCntNext = filtCnt - 2'd1;
        end
    end

    // The filtered bit only flips once the counter saturates, giving hysteresis.
    always_ff @(posedge clk) begin
        if (rst) begin
            filtCnt <= 2'd3;
            filtBit <= 1'b1;
        end else if (tick) begin
            filtCnt <= filtCntNext;
            if (filtCntNext == 2'd3) begin
                filtBit <= 1'b1;
            end else if (filtCntNext == 2'd0) begin
                filtBit <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            osCnt <= '0;
        end else if (tick) begin
            osCnt <= osCnt + 1'b1;
        end
    end

    assign sampleNow = tick && (osCnt == OsWidth'(Oversampling / 2 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            shiftReg       <= 8'h00;
            RxD_data       <= 8'h00;
            RxD_data_ready <= 1'b0;
        end else begin
            RxD_data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && !filtBit) begin
                        state <= START;
                    end
                end
                START: begin
                    if (sampleNow) begin
                        state <= filtBit ? IDLE : BIT0;
                    end
                end
                STOP: begin
                    // A low stop bit is a framing error: the byte is dropped silently.
                    if (sampleNow) begin
                        if (filtBit) begin
                            RxD_data       <= shiftReg;
                            RxD_data_ready <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    if (state >= BIT0 && state <= BIT7) begin
                        if (sampleNow) begin
                            shiftReg <= {filtBit, shiftReg[7:1]};
                            state    <= state + 4'd1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_async_receiver.sv
// Bench for async_receiver: frames are driven at the nominal bit time and the received
// bytes are scored against a queue of the bytes the bench sent with a valid stop bit.
`timescale 1ns/1ps
module tb_async_receiver;

    localparam int BitNs    = 8680;
    localparam int LatMinNs = 82000;
    localparam int LatMaxNs = 95000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;

    int         nChecks   = 0;
    int         nFails    = 0;
    int         pulses    = 0;
    int         expPulses = 0;
    logic [7:0] lastByte  = 8'h00;
    logic       prevReady = 1'b0;
    logic [7:0] exp_q[$];
    realtime    start_q[$];
    logic [7:0] expByte;
    realtime    startTime;
    realtime    lat;

    always #10 clk = ~clk;

    async_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .RxD            (RxD),
        .RxD_data_ready (RxD_data_ready),
        .RxD_data       (RxD_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a frame with a high stop bit yields exactly one byte, in order.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        if (stopBit) begin
            exp_q.push_back(b);
            start_q.push_back($realtime);
            expPulses++;
            lastByte = b;
        end
        RxD = 1'b0;
        #(BitNs);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            #(BitNs);
        end
        RxD = stopBit;
        #(BitNs);
        RxD = 1'b1;
    endtask

    task automatic idleBits(input int n);
        #(n * BitNs);
    endtask

    task automatic checkState(input string tag);
        check({tag, " pulses"}, pulses, expPulses);
        check({tag, " data"}, {24'h0, RxD_data}, {24'h0, lastByte});
    endtask

    always @(negedge clk) begin
        if (RxD_data_ready) begin
            pulses = pulses + 1;
            if (prevReady) begin
                check("ready twice in a row", 1, 0);
            end
            if (exp_q.size() == 0) begin
                check("unexpected ready pulse", 1, 0);
            end else begin
                expByte   = exp_q.pop_front();
                startTime = start_q.pop_front();
                lat       = $realtime - startTime;
                check("received byte", {24'h0, RxD_data}, {24'h0, expByte});
                check("ready latency in window",
                      32'((lat >= LatMinNs) && (lat <= LatMaxNs)), 1);
            end
        end
        prevReady <= RxD_data_ready;
    end

    initial begin
        logic [7:0] b;
        logic       bad;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data", {24'h0, RxD_data}, 0);
        check("reset ready", {31'h0, RxD_data_ready}, 0);
        rst = 1'b0;
        #50000;
        checkState("idle line");

        RxD = 1'b0;
        #29;
        RxD = 1'b1;
        #50000;
        checkState("glitch");

        sendFrame(8'h55, 1'b1);
        idleBits(3);
        checkState("single 0x55");

        sendFrame(8'hA3, 1'b1);
        sendFrame(8'h0F, 1'b1);
        idleBits(3);
        checkState("back-to-back");

        sendFrame(8'h3C, 1'b0);
        idleBits(2);
        checkState("framing error");
        sendFrame(8'h81, 1'b1);
        idleBits(3);
        checkState("after framing error");

        // Start a 0xFF frame and reset while the receiver is shifting data bit 4.
        RxD = 1'b0;
        #(BitNs);
        RxD = 1'b1;
        #(5 * BitNs);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-frame reset data", {24'h0, RxD_data}, 0);
        check("mid-frame reset ready", {31'h0, RxD_data_ready}, 0);
        lastByte = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        idleBits(6);
        checkState("after mid-frame reset");
        sendFrame(8'h12, 1'b1);
        idleBits(3);
        checkState("frame 0x12");

        for (int k = 0; k < 3; k++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            sendFrame(b, !bad);
            idleBits(bad ? $urandom_range(1, 3) : $urandom_range(0, 2));
        end
        idleBits(3);
        checkState("random frames");
        check("expected queue drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
